nn_layer_stream: RTL
====================

# nn_layer_stream

Parametrised fully-connected layer: NN `neuron` instances in a generate loop share one input stream and one runtime weight/bias load bus. Results are captured into an output buffer and serialised one value per cycle, so the stream drives the next layer's `x_in` directly. An optional argmax tracker reports the winning neuron on the final layer. Sits between consecutive layers in the network top, replacing the fixed per-layer wrappers plus their external shift logic.

## Interface
Parameters:
- NN, 30, neuron count (≥2)
- numWeight, 784, inputs per neuron (stream length per inference)
- dataWidth, 16, signed fixed-point data width
- layerNum, 1, layer index matched against config_layer_num
- sigmoidSize, 10, sigmoid LUT address width
- weightIntWidth, 4, integer bits of weights
- actType, "relu", activation ("relu" or "sigmoid")

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- weightValid  in  1  weight write strobe
- biasValid  in  1  bias write strobe
- weightValue  in  32  weight write data
- biasValue  in  32  bias write data
- config_layer_num  in  32  target layer of write
- config_neuron_num  in  32  target neuron of write
- x_valid  in  1  input sample valid
- x_in  in  dataWidth  input sample
- out_valid  out  1  serialised output valid
- out_data  out  dataWidth  serialised neuron output, index order 0..NN-1
- out_last  out  1  high with element NN-1
- busy  out  1  serialiser active
- overrun  out  1  sticky: capture arrived while busy
- max_valid  out  1  one-cycle argmax result strobe
- max_idx  out  $clog2(NN)  index of largest output
- max_val  out  dataWidth  largest output value

## Operation
- All neurons get identical x_in/x_valid and the load bus; neuron n has neuronNo=n, layerNo=layerNum; weight/bias init files per team naming.
- Capture event: AND of all NN neuron outvalid bits. A partial set is ignored.
- FSM IDLE / SHIFT:
  - IDLE + capture: load all NN outputs into buffer, idx←0, go SHIFT.
  - SHIFT: out_data=buf[idx], out_valid=1; idx increments each cycle.
  - At idx=NN-1: out_last=1. With no capture in that cycle, go IDLE.
  - At idx=NN-1 with a capture in the same cycle: reload buffer, idx←0, stay SHIFT. No gap cycle; not an overrun.
  - SHIFT + capture at idx<NN-1: capture dropped, overrun←1 (sticky until rst), current stream continues unchanged.
- busy = (state==SHIFT).
- No backpressure; downstream must accept every out_valid cycle.
- rst mid-stream: FSM→IDLE, idx=0, buffer cleared, stream abandoned.
- Neuron internal state resets with the same rst.

## Timing
- Capture at edge C → out_valid high for cycles C+1..C+NN, out_last at C+NN.
- max_valid at C+NN+1 (argmax build only).
- Input-to-output latency is neuron pipeline latency + 1 cycle.
- Reset values: out_valid=0, out_data=0, out_last=0, busy=0, overrun=0, max_valid=0, max_idx=0, max_val=0.

## Configuration
- Macro NN_LAYER_ARGMAX_EN.
- Defined:
  - Tracker compares each streamed element as a signed dataWidth value.
  - Tracker is seeded with element 0.
  - A later element replaces the current best only if it is strictly greater, so ties keep the lower index.
  - max_idx/max_val are registered and held until the next result; max_valid pulses one cycle.
  - Back-to-back reload re-seeds from the new element 0.
- Undefined: no tracker logic; max_valid, max_idx and max_val tied to 0.

## Structure
- Package nn_layer_pkg:
  - FSM state enum (IDLE, SHIFT).
  - Index-width helper returning $clog2(NN), min 1.
  - Fixed-point sign/compare helper used by the argmax tracker.
- Sub-module: existing `neuron`, instantiated NN times via generate.
- Serialiser + argmax stay in this module; optional split into `nn_layer_serialiser` if reused by other layer types.

## Test plan
- NN=4, dataWidth=16, weights loaded so outputs are 0x0010, 0x0200, 0x0030, 0x0200 → stream 0x0010, 0x0200, 0x0030, 0x0200 on C+1..C+4; out_last at C+4; max_idx=1, max_val=0x0200 at C+5.
- Runtime load with config_layer_num≠layerNum → neuron weights unchanged; same stimulus gives identical outputs.
- Force capture at idx=NN-1 → second stream starts at C+NN+1 with no gap; overrun stays 0.
- Force capture at idx=1 → overrun=1 and held; first stream completes intact; second result discarded.
- Assert rst at idx=2 → next cycle out_valid=0, busy=0, overrun=0; a fresh inference then streams all NN values.
- Build without NN_LAYER_ARGMAX_EN → max_* outputs constant 0 through a full inference; stream identical to the argmax build.

Source files
------------

// File: rtl/nn_layer_stream_pkg.sv
// nn_layer_pkg: shared types and helpers for the streaming FC layer.
// Holds the serialiser FSM state, index width and signed compare helpers.
package nn_layer_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } nn_state_e;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Signed compare of two w-bit values carried in 32-bit containers:
  // left-aligning puts the sign bit at bit 31.
  function automatic logic fx_gt(
    input logic [31:0] a,
    input logic [31:0] b,
    input int          w
  );
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = signed'(a << (32 - w));
    sb = signed'(b << (32 - w));
    return sa > sb;
  endfunction

endpackage

// File: rtl/nn_layer_stream_if.sv
// nn_layer_stream_if: load bus, input stream and serialised outputs.
// slave = layer side, master = driver / next-layer side.
interface nn_layer_stream_if #(
  parameter int dataWidth = 16,
  parameter int NN        = 30
);
  localparam int IW = nn_layer_pkg::idx_w(NN);

  logic                 weightValid;
  logic                 biasValid;
  logic [31:0]          weightValue;
  logic [31:0]          biasValue;
  logic [31:0]          config_layer_num;
  logic [31:0]          config_neuron_num;
  logic                 x_valid;
  logic [dataWidth-1:0] x_in;
  logic                 out_valid;
  logic [dataWidth-1:0] out_data;
  logic                 out_last;
  logic                 busy;
  logic                 overrun;
  logic                 max_valid;
  logic [IW-1:0]        max_idx;
  logic [dataWidth-1:0] max_val;

  modport slave (
    input  weightValid, biasValid,
    input  weightValue, biasValue,
    input  config_layer_num,
    input  config_neuron_num,
    input  x_valid, x_in,
    output out_valid, out_data,
    output out_last, busy, overrun,
    output max_valid, max_idx, max_val
  );

  modport master (
    output weightValid, biasValid,
    output weightValue, biasValue,
    output config_layer_num,
    output config_neuron_num,
    output x_valid, x_in,
    input  out_valid, out_data,
    input  out_last, busy, overrun,
    input  max_valid, max_idx, max_val
  );

endinterface

// File: rtl/nn_layer_stream_neuron.sv
// neuron: MAC over numWeight streamed inputs, bias add, activation.
// Ports: clk/rst, myinput(+Valid), weight/bias load bus, out/outvalid.
module neuron #(
  parameter int    layerNo        = 0,
  parameter int    neuronNo       = 0,
  parameter int    numWeight      = 784,
  parameter int    dataWidth      = 16,
  parameter int    sigmoidSize    = 10,
  parameter int    weightIntWidth = 4,
  parameter string actType        = "relu"
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [dataWidth-1:0] myinput,
  input  logic                 myinputValid,
  input  logic                 weightValid,
  input  logic                 biasValid,
  input  logic [31:0]          weightValue,
  input  logic [31:0]          biasValue,
  input  logic [31:0]          config_layer_num,
  input  logic [31:0]          config_neuron_num,
  output logic [dataWidth-1:0] out,
  output logic                 outvalid
);
  localparam int AW  = (numWeight > 1) ?
                       $clog2(numWeight) : 1;
  localparam int FW  = dataWidth - weightIntWidth;
  localparam int ACW = 2 * dataWidth + AW + 2;
  localparam int EW  = dataWidth + 2;
  localparam int QS  = dataWidth - sigmoidSize;
  localparam bit IS_RELU = (actType == "relu");
  localparam logic [AW-1:0] WLAST = AW'(numWeight - 1);
  localparam logic signed [ACW-1:0] SMAX =
    ACW'((2 ** (dataWidth - 1)) - 1);
  localparam logic signed [ACW-1:0] SMIN = -SMAX - 1;
  localparam logic signed [EW-1:0] ONE  = EW'(1 << FW);
  localparam logic signed [EW-1:0] HALF = EW'(1 << (FW - 1));

  logic signed [dataWidth-1:0] w_q [numWeight];
  logic signed [dataWidth-1:0] bias_q;
  logic [AW-1:0]               waddr_q;
  logic [AW-1:0]               raddr_q;
  logic signed [ACW-1:0]       acc_q;
  logic [dataWidth-1:0]        out_q;
  logic                        ov_q;

  logic                        sel;
  logic signed [2*dataWidth-1:0] prod;
  logic signed [ACW-1:0]       sum_d;
  logic signed [ACW-1:0]       sh_d;
  logic signed [dataWidth-1:0] sat_d;
  logic signed [EW-1:0]        sq_d;
  logic signed [EW-1:0]        sy_d;
  logic [dataWidth-1:0]        act_d;
  logic                        unused_hi;

  assign unused_hi = ^{weightValue[31:dataWidth],
                       biasValue[31:dataWidth]};

  assign sel = (config_layer_num == 32'(layerNo)) &&
               (config_neuron_num == 32'(neuronNo));

  assign prod = signed'(myinput) * w_q[raddr_q];

  always_comb begin
    sum_d = acc_q + ACW'(prod) +
            (ACW'(bias_q) <<< FW);
    sh_d  = sum_d >>> FW;
    if (sh_d > SMAX)      sat_d = {1'b0, {(dataWidth-1){1'b1}}};
    else if (sh_d < SMIN) sat_d = {1'b1, {(dataWidth-1){1'b0}}};
    else                  sat_d = sh_d[dataWidth-1:0];
    // Hard sigmoid 0.5 + x/4 on an input quantised to sigmoidSize bits.
    sq_d = EW'(sat_d);
    sq_d = (sq_d >>> QS) <<< QS;
    sy_d = HALF + (sq_d >>> 2);
    if (IS_RELU) begin
      act_d = sat_d[dataWidth-1] ? '0 : sat_d;
    end else if (sy_d < 0) begin
      act_d = '0;
    end else if (sy_d > ONE) begin
      act_d = ONE[dataWidth-1:0];
    end else begin
      act_d = sy_d[dataWidth-1:0];
    end
  end

  // Weight store survives rst so a reset does not require a reload.
  always_ff @(posedge clk) begin
    if (weightValid && sel)
      w_q[waddr_q] <= weightValue[dataWidth-1:0];
    if (biasValid && sel)
      bias_q <= biasValue[dataWidth-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr_q <= '0;
      raddr_q <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      if (weightValid && sel)
        waddr_q <= (waddr_q == WLAST) ?
                   '0 : waddr_q + 1'b1;
      ov_q <= 1'b0;
      if (myinputValid) begin
        if (raddr_q == WLAST) begin
          raddr_q <= '0;
          acc_q   <= '0;
          out_q   <= act_d;
          ov_q    <= 1'b1;
        end else begin
          raddr_q <= raddr_q + 1'b1;
          acc_q   <= acc_q + ACW'(prod);
        end
      end
    end
  end

  assign out      = out_q;
  assign outvalid = ov_q;

endmodule

// File: rtl/nn_layer_stream.sv
// nn_layer_stream: NN neurons on a shared stream, serialised output.
// Ports: clk, rst, bus (nn_layer_stream_if.slave). Macro NN_LAYER_ARGMAX_EN.
module nn_layer_stream
  import nn_layer_pkg::*;
#(
  parameter int    NN             = 30,
  parameter int    numWeight      = 784,
  parameter int    dataWidth      = 16,
  parameter int    layerNum       = 1,
  parameter int    sigmoidSize    = 10,
  parameter int    weightIntWidth = 4,
  parameter string actType        = "relu"
) (
  input logic              clk,
  input logic              rst,
  nn_layer_stream_if.slave bus
);
  localparam int DW = dataWidth;
  localparam int IW = idx_w(NN);
  localparam logic [IW-1:0] LAST = IW'(NN - 1);

  logic [NN-1:0] nv;
  logic [DW-1:0] nout [NN];

  for (genvar n = 0; n < NN; n++) begin : g_n
    neuron #(
      .layerNo       (layerNum),
      .neuronNo      (n),
      .numWeight     (numWeight),
      .dataWidth     (dataWidth),
      .sigmoidSize   (sigmoidSize),
      .weightIntWidth(weightIntWidth),
      .actType       (actType)
    ) u_neuron (
      .clk              (clk),
      .rst              (rst),
      .myinput          (bus.x_in),
      .myinputValid     (bus.x_valid),
      .weightValid      (bus.weightValid),
      .biasValid        (bus.biasValid),
      .weightValue      (bus.weightValue),
      .biasValue        (bus.biasValue),
      .config_layer_num (bus.config_layer_num),
      .config_neuron_num(bus.config_neuron_num),
      .out              (nout[n]),
      .outvalid         (nv[n])
    );
  end

  nn_state_e     state_q;
  logic [IW-1:0] idx_q;
  logic [DW-1:0] buf_q [NN];
  logic [DW-1:0] dat_q;
  logic          vld_q;
  logic          last_q;
  logic          ovr_q;

  logic          cap;
  logic          load;
  logic [IW-1:0] nxt;

  assign cap  = &nv;
  // A capture on the final element chains straight into a new stream.
  assign load = cap && ((state_q == IDLE) ||
                        (idx_q == LAST));
  assign nxt  = idx_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int i = 0; i < NN; i++)
        buf_q[i] <= '0;
      dat_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (load) begin
      state_q <= SHIFT;
      idx_q   <= '0;
      for (int i = 0; i < NN; i++)
        buf_q[i] <= nout[i];
      dat_q   <= nout[0];
      vld_q   <= 1'b1;
      last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        SHIFT: begin
          if (idx_q == LAST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dat_q   <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
          end else begin
            idx_q  <= nxt;
            dat_q  <= buf_q[nxt];
            last_q <= (nxt == LAST);
            ovr_q  <= ovr_q | cap;
          end
        end
      endcase
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.out_data  = dat_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = (state_q == SHIFT);
  assign bus.overrun   = ovr_q;

`ifdef NN_LAYER_ARGMAX_EN
  logic [DW-1:0] best_q;
  logic [IW-1:0] bidx_q;
  logic [DW-1:0] mval_q;
  logic [IW-1:0] midx_q;
  logic          mv_q;
  logic          gt;

  assign gt = fx_gt(32'(dat_q), 32'(best_q), DW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_q <= '0;
      bidx_q <= '0;
      mval_q <= '0;
      midx_q <= '0;
      mv_q   <= 1'b0;
    end else begin
      mv_q <= 1'b0;
      if (vld_q) begin
        if (idx_q == '0) begin
          best_q <= dat_q;
          bidx_q <= '0;
        end else if (gt) begin
          best_q <= dat_q;
          bidx_q <= idx_q;
        end
        // Final element is folded in directly to avoid a second cycle.
        if (idx_q == LAST) begin
          mv_q   <= 1'b1;
          mval_q <= gt ? dat_q : best_q;
          midx_q <= gt ? idx_q : bidx_q;
        end
      end
    end
  end

  assign bus.max_valid = mv_q;
  assign bus.max_idx   = midx_q;
  assign bus.max_val   = mval_q;
`else
  assign bus.max_valid = 1'b0;
  assign bus.max_idx   = '0;
  assign bus.max_val   = '0;
`endif

endmodule
